// File: rtl/event_report_builder.sv
// Per-window timestamp statistics collector; emits a fixed 6-beat AXI-Stream
// report (n, logger count, first, last, min gap, max gap) when the count beat arrives.
module event_report_builder #(
  parameter logic [15:0] REPORT_DEST = 16'h0000,
  parameter logic [15:0] REPORT_ID   = 16'h0000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [63:0] ts_TDATA,
  input  logic [7:0]  ts_TKEEP,
  input  logic        ts_TLAST,
  input  logic        ts_TVALID,
  output logic        ts_TREADY,
  input  logic [63:0] cnt_TDATA,
  input  logic [7:0]  cnt_TKEEP,
  input  logic        cnt_TLAST,
  input  logic        cnt_TVALID,
  output logic        cnt_TREADY,
  output logic [63:0] report_TDATA,
  output logic [7:0]  report_TKEEP,
  output logic [15:0] report_TDEST,
  output logic [15:0] report_TID,
  output logic        report_TVALID,
  input  logic        report_TREADY,
  output logic        report_TLAST,
  output logic        count_mismatch,
  output logic        ts_backward
);

  typedef enum logic {COLLECT, REPORT} state_t;
  state_t state;

  logic [63:0] n, first_ts, last_ts, min_gap, max_gap, logger_cnt;
  logic [2:0]  beat;

  logic        ts_hs, cnt_hs, rpt_hs;
  logic [63:0] gap;
  logic [63:0] n_nxt, first_nxt, last_nxt, min_nxt, max_nxt;
  logic        bwd;
  logic [2:0]  beat_sel;
  logic [63:0] next_word;

  logic unused_ok;
  assign unused_ok = ^{ts_TKEEP, ts_TLAST, cnt_TKEEP, cnt_TLAST};

  assign report_TKEEP = 8'hFF;
  assign report_TDEST = REPORT_DEST;
  assign report_TID   = REPORT_ID;

  assign ts_hs  = ts_TVALID & ts_TREADY;
  assign cnt_hs = cnt_TVALID & cnt_TREADY;
  assign rpt_hs = report_TVALID & report_TREADY;
  assign gap    = ts_TDATA - last_ts;

  // Statistics as they stand after this cycle's timestamp, so a count beat in
  // the same cycle reports a window that already includes it.
  always_comb begin
    n_nxt     = n;
    first_nxt = first_ts;
    last_nxt  = last_ts;
    min_nxt   = min_gap;
    max_nxt   = max_gap;
    bwd       = 1'b0;
    if (ts_hs) begin
      n_nxt    = (n == '1) ? n : n + 64'd1;
      last_nxt = ts_TDATA;
      if (n == '0) begin
        first_nxt = ts_TDATA;
      end else begin
        bwd = (ts_TDATA < last_ts);
        if (gap < min_gap) min_nxt = gap;
        if (gap > max_gap) max_nxt = gap;
      end
    end
  end

  assign beat_sel = beat + 3'd1;

  always_comb begin
    next_word = '0;
    case (beat_sel)
      3'd1:    next_word = logger_cnt;
      3'd2:    next_word = (n == '0) ? '0 : first_ts;
      3'd3:    next_word = (n == '0) ? '0 : last_ts;
      3'd4:    next_word = (n < 64'd2) ? '0 : min_gap;
      3'd5:    next_word = (n < 64'd2) ? '0 : max_gap;
      default: next_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state          <= COLLECT;
      n              <= '0;
      first_ts       <= '0;
      last_ts        <= '0;
      min_gap        <= '1;
      max_gap        <= '0;
      logger_cnt     <= '0;
      beat           <= '0;
      ts_TREADY      <= 1'b0;
      cnt_TREADY     <= 1'b0;
      report_TDATA   <= '0;
      report_TVALID  <= 1'b0;
      report_TLAST   <= 1'b0;
      count_mismatch <= 1'b0;
      ts_backward    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          n           <= n_nxt;
          first_ts    <= first_nxt;
          last_ts     <= last_nxt;
          min_gap     <= min_nxt;
          max_gap     <= max_nxt;
          ts_backward <= ts_backward | bwd;
          if (cnt_hs) begin
            logger_cnt     <= cnt_TDATA;
            beat           <= '0;
            report_TDATA   <= n_nxt;
            report_TLAST   <= 1'b0;
            report_TVALID  <= 1'b1;
            count_mismatch <= (n_nxt != cnt_TDATA);
            ts_TREADY      <= 1'b0;
            cnt_TREADY     <= 1'b0;
            state          <= REPORT;
          end else begin
            ts_TREADY  <= 1'b1;
            cnt_TREADY <= 1'b1;
          end
        end
        REPORT: begin
          if (rpt_hs) begin
            if (beat == 3'd5) begin
              report_TVALID <= 1'b0;
              report_TLAST  <= 1'b0;
              n             <= '0;
              first_ts      <= '0;
              last_ts       <= '0;
              min_gap       <= '1;
              max_gap       <= '0;
              ts_backward   <= 1'b0;
              ts_TREADY     <= 1'b1;
              cnt_TREADY    <= 1'b1;
              state         <= COLLECT;
            end else begin
              beat         <= beat_sel;
              report_TDATA <= next_word;
              report_TLAST <= (beat_sel == 3'd5);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_event_report_builder.sv
// Directed bench for event_report_builder: expected report beats are queued when
// a window is closed and compared as each report handshake occurs.
module tb_event_report_builder;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [63:0] ts_TDATA, cnt_TDATA, report_TDATA;
  logic [7:0]  ts_TKEEP, cnt_TKEEP, report_TKEEP;
  logic        ts_TLAST, ts_TVALID, ts_TREADY;
  logic        cnt_TLAST, cnt_TVALID, cnt_TREADY;
  logic [15:0] report_TDEST, report_TID;
  logic        report_TVALID, report_TREADY, report_TLAST;
  logic        count_mismatch, ts_backward;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  event_report_builder #(.REPORT_DEST(16'h0000), .REPORT_ID(16'h0000)) dut (
    .clk(clk), .aresetn(aresetn),
    .ts_TDATA(ts_TDATA), .ts_TKEEP(ts_TKEEP), .ts_TLAST(ts_TLAST),
    .ts_TVALID(ts_TVALID), .ts_TREADY(ts_TREADY),
    .cnt_TDATA(cnt_TDATA), .cnt_TKEEP(cnt_TKEEP), .cnt_TLAST(cnt_TLAST),
    .cnt_TVALID(cnt_TVALID), .cnt_TREADY(cnt_TREADY),
    .report_TDATA(report_TDATA), .report_TKEEP(report_TKEEP),
    .report_TDEST(report_TDEST), .report_TID(report_TID),
    .report_TVALID(report_TVALID), .report_TREADY(report_TREADY),
    .report_TLAST(report_TLAST),
    .count_mismatch(count_mismatch), .ts_backward(ts_backward)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_report(input logic [63:0] b0, b1, b2, b3, b4, b5);
    logic [63:0] w[6];
    w = '{b0, b1, b2, b3, b4, b5};
    for (int i = 0; i < 6; i++) q.push_back('{data: w[i], last: (i == 5)});
  endtask

  task automatic send_ts(input logic [63:0] d);
    @(negedge clk);
    check("ts_ready_collect", {63'd0, ts_TREADY}, 64'd1);
    ts_TVALID = 1'b1;
    ts_TDATA  = d;
    @(negedge clk);
    ts_TVALID = 1'b0;
  endtask

  task automatic send_cnt(input logic [63:0] c);
    @(negedge clk);
    check("cnt_ready_collect", {63'd0, cnt_TREADY}, 64'd1);
    cnt_TVALID = 1'b1;
    cnt_TDATA  = c;
    @(negedge clk);
    cnt_TVALID = 1'b0;
  endtask

  // Consume nbeats report handshakes; pat[cycle%4] drives report_TREADY.
  task automatic drain(input int nbeats, input logic [3:0] pat);
    int hs = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [63:0] held = '0;
    beat_t e;
    while (hs < nbeats && cyc < 40) begin
      @(negedge clk);
      if (stalled) begin
        check("hold_data", report_TDATA, held);
        check("hold_valid", {63'd0, report_TVALID}, 64'd1);
      end
      report_TREADY = pat[cyc % 4];
      check("ts_ready_report", {63'd0, ts_TREADY}, 64'd0);
      check("cnt_ready_report", {63'd0, cnt_TREADY}, 64'd0);
      if (report_TVALID && report_TREADY) begin
        if (q.size() == 0) begin
          check("queue_empty", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("beat_data", report_TDATA, e.data);
          check("beat_last", {63'd0, report_TLAST}, {63'd0, e.last});
        end
        hs++;
        stalled = 1'b0;
      end else if (report_TVALID) begin
        stalled = 1'b1;
        held = report_TDATA;
      end
      cyc++;
    end
    if (hs < nbeats) check("drain_timeout", 64'(hs), 64'(nbeats));
  endtask

  task automatic end_check();
    @(negedge clk);
    report_TREADY = 1'b0;
    check("valid_after_report", {63'd0, report_TVALID}, 64'd0);
    check("ts_ready_after", {63'd0, ts_TREADY}, 64'd1);
    check("cnt_ready_after", {63'd0, cnt_TREADY}, 64'd1);
  endtask

  initial begin
    aresetn = 1'b0;
    ts_TDATA = '0; ts_TKEEP = 8'hFF; ts_TLAST = 1'b0; ts_TVALID = 1'b0;
    cnt_TDATA = '0; cnt_TKEEP = 8'hFF; cnt_TLAST = 1'b0; cnt_TVALID = 1'b0;
    report_TREADY = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, report_TVALID}, 64'd0);
    check("rst_ts_ready", {63'd0, ts_TREADY}, 64'd0);
    check("rst_cnt_ready", {63'd0, cnt_TREADY}, 64'd0);
    check("rst_data", report_TDATA, 64'd0);
    check("rst_flags", {62'd0, count_mismatch, ts_backward}, 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // Four increasing timestamps, matching count
    send_ts(64'd100); send_ts(64'd130); send_ts(64'd135); send_ts(64'd200);
    push_report(64'd4, 64'd4, 64'd100, 64'd200, 64'd5, 64'd65);
    send_cnt(64'd4);
    check("mismatch_w1", {63'd0, count_mismatch}, 64'd0);
    check("keep", {56'd0, report_TKEEP}, 64'hFF);
    check("dest_id", {32'd0, report_TDEST, report_TID}, 64'd0);
    drain(6, 4'hF);
    end_check();

    // Empty window, count 3
    push_report(64'd0, 64'd3, 64'd0, 64'd0, 64'd0, 64'd0);
    send_cnt(64'd3);
    check("mismatch_w2", {63'd0, count_mismatch}, 64'd1);
    drain(6, 4'hF);
    end_check();
    check("mismatch_held", {63'd0, count_mismatch}, 64'd1);

    // Single timestamp, stalled report (ready 1-0-0-1 pattern)
    send_ts(64'd50);
    push_report(64'd1, 64'd1, 64'd50, 64'd50, 64'd0, 64'd0);
    send_cnt(64'd1);
    check("mismatch_w3", {63'd0, count_mismatch}, 64'd0);
    drain(6, 4'b1001);
    end_check();

    // Backward timestamp
    send_ts(64'd500); send_ts(64'd400);
    push_report(64'd2, 64'd2, 64'd500, 64'd400,
                64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FF9C);
    send_cnt(64'd2);
    check("backward_set", {63'd0, ts_backward}, 64'd1);
    drain(6, 4'hF);
    end_check();
    check("backward_clear", {63'd0, ts_backward}, 64'd0);

    // Timestamp and count in the same cycle
    @(negedge clk);
    ts_TVALID = 1'b1; ts_TDATA = 64'd10;
    cnt_TVALID = 1'b1; cnt_TDATA = 64'd1;
    push_report(64'd1, 64'd1, 64'd10, 64'd10, 64'd0, 64'd0);
    @(negedge clk);
    ts_TVALID = 1'b0; cnt_TVALID = 1'b0;
    check("mismatch_simul", {63'd0, count_mismatch}, 64'd0);
    drain(6, 4'hF);
    end_check();

    // Reset during beat 2 of a report
    send_ts(64'd7);
    push_report(64'd1, 64'd1, 64'd7, 64'd7, 64'd0, 64'd0);
    send_cnt(64'd1);
    drain(2, 4'hF);
    @(negedge clk);
    report_TREADY = 1'b0;
    check("beat2_valid", {63'd0, report_TVALID}, 64'd1);
    check("beat2_data", report_TDATA, 64'd7);
    aresetn = 1'b0;
    @(negedge clk);
    check("midrst_valid", {63'd0, report_TVALID}, 64'd0);
    check("midrst_ts_ready", {63'd0, ts_TREADY}, 64'd0);
    q.delete();
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    send_ts(64'd20);
    push_report(64'd1, 64'd1, 64'd20, 64'd20, 64'd0, 64'd0);
    send_cnt(64'd1);
    check("fresh_mismatch", {63'd0, count_mismatch}, 64'd0);
    drain(6, 4'hF);
    end_check();
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
